i2s_receiver: RTL and testbench

- Deserializes an incoming I2S stream (bit_clk, frame_clk, data) from an external ADC/codec into parallel left/right PCM samples.
- Mirror of the system's I2S transmit path. Its outputs feed the mixer or loopback/monitor logic.
- Runs on a single fast system clock and oversamples the serial lines; the serial lines are never used as clocks.

---
 rtl/i2s_receiver_pkg.sv | 13 +
 rtl/i2s_receiver_sync_edge_detect.sv | 30 +++
 rtl/i2s_receiver.sv | 158 +++++++++++++++
 tb/tb_i2s_receiver.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_receiver_pkg.sv
// Shared I2S definitions: receiver state encoding and channel constants.
package i2s_receiver_pkg;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    SHIFT = 2'd1,
    PAD   = 2'd2
  } state_t;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

endpackage

// File: rtl/i2s_receiver_sync_edge_detect.sv
// Aligned synchronizer for the three I2S pins plus bit_clk rising-edge tick.
module sync_edge_detect #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic bit_clk,
  input  logic frame_clk,
  input  logic data,
  output logic tick,
  output logic ws,
  output logic sd
);

  // One chain carries all three lines so ws/sd line up with the tick
  logic [2:0] chain [STAGES];
  logic       bclk_q;

  always_ff @(posedge clk) begin
    chain[0] <= {data, frame_clk, bit_clk};
    for (int i = 1; i < STAGES; i++) begin
      chain[i] <= chain[i-1];
    end
    bclk_q <= chain[STAGES-1][0];
  end

  assign tick = chain[STAGES-1][0] & ~bclk_q;
  assign ws   = chain[STAGES-1][1];
  assign sd   = chain[STAGES-1][2];

endmodule

// File: rtl/i2s_receiver.sv
// I2S deserializer: oversamples bit_clk/frame_clk/data on clk and
// presents complete left/right PCM pairs.
module i2s_receiver
  import i2s_receiver_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    bit_clk,
  input  logic                    frame_clk,
  input  logic                    data,
  output logic [SAMPLE_WIDTH-1:0] sample_left,
  output logic [SAMPLE_WIDTH-1:0] sample_right,
  output logic                    sample_valid,
  output logic                    frame_err,
  output logic                    locked
);

  localparam int CW = $clog2(SAMPLE_WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(SAMPLE_WIDTH - 1);

  logic tick;
  logic ws;
  logic sd;

  sync_edge_detect #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .bit_clk  (bit_clk),
    .frame_clk(frame_clk),
    .data     (data),
    .tick     (tick),
    .ws       (ws),
    .sd       (sd)
  );

  state_t                  state, state_n;
  logic [CW-1:0]           count, count_n;
  logic [SAMPLE_WIDTH-1:0] shreg, shreg_n;
  logic [SAMPLE_WIDTH-1:0] hold, hold_n;
  logic [SAMPLE_WIDTH-1:0] left_n, right_n;
  logic [SAMPLE_WIDTH-1:0] word;
  logic                    left_ok, left_ok_n;
  logic                    channel, channel_n;
  logic                    ws_prev, ws_prev_n;
  logic                    primed, primed_n;
  logic                    locked_n;
  logic                    valid_n;
  logic                    err_n;
  logic                    bnd;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= SYNC;
      count        <= '0;
      shreg        <= '0;
      hold         <= '0;
      left_ok      <= 1'b0;
      channel      <= CH_LEFT;
      ws_prev      <= 1'b0;
      primed       <= 1'b0;
      locked       <= 1'b0;
      sample_left  <= '0;
      sample_right <= '0;
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      state        <= state_n;
      count        <= count_n;
      shreg        <= shreg_n;
      hold         <= hold_n;
      left_ok      <= left_ok_n;
      channel      <= channel_n;
      ws_prev      <= ws_prev_n;
      primed       <= primed_n;
      locked       <= locked_n;
      sample_left  <= left_n;
      sample_right <= right_n;
      sample_valid <= valid_n;
      frame_err    <= err_n;
    end
  end

  // A boundary needs a previously sampled ws, so a stream that starts
  // mid-slot does not lock on the stale ws_prev left by reset
  assign bnd = primed && (ws != ws_prev);

  always_comb begin
    state_n   = state;
    count_n   = count;
    shreg_n   = shreg;
    hold_n    = hold;
    left_ok_n = left_ok;
    channel_n = channel;
    ws_prev_n = ws_prev;
    primed_n  = primed;
    locked_n  = locked;
    left_n    = sample_left;
    right_n   = sample_right;
    valid_n   = 1'b0;
    err_n     = 1'b0;
    word      = {shreg[SAMPLE_WIDTH-2:0], sd};
    if (tick) begin
      ws_prev_n = ws;
      primed_n  = 1'b1;
      unique case (state)
        SYNC: begin
          if (bnd) begin
            locked_n  = 1'b1;
            channel_n = ws;
            count_n   = '0;
            shreg_n   = '0;
            state_n   = SHIFT;
          end
        end
        SHIFT: begin
          if (bnd) begin
            err_n     = 1'b1;
            left_ok_n = 1'b0;
            channel_n = ws;
            count_n   = '0;
            shreg_n   = '0;
          end else begin
            shreg_n = word;
            count_n = count + 1'b1;
            if (count == LAST) begin
              state_n = PAD;
              if (channel == CH_RIGHT) begin
                if (left_ok) begin
                  left_n    = hold;
                  right_n   = word;
                  valid_n   = 1'b1;
                  left_ok_n = 1'b0;
                end
              end else begin
                hold_n    = word;
                left_ok_n = 1'b1;
              end
            end
          end
        end
        PAD: begin
          if (bnd) begin
            channel_n = ws;
            count_n   = '0;
            shreg_n   = '0;
            state_n   = SHIFT;
          end
        end
        default: state_n = SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_receiver.sv
// Directed bench for i2s_receiver: framing, errors, reset and streaming.
module tb_i2s_receiver;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        bit_clk = 1'b0;
  logic        frame_clk = 1'b0;
  logic        data = 1'b0;
  logic [15:0] sample_left;
  logic [15:0] sample_right;
  logic        sample_valid;
  logic        frame_err;
  logic        locked;

  int n_checks = 0;
  int n_fail = 0;
  int h = 8;

  int          cyc = 0;
  int          np = 0;
  int          ne = 0;
  int          both = 0;
  logic [15:0] lg_l [256];
  logic [15:0] lg_r [256];
  int          lg_c [256];

  i2s_receiver #(
    .SAMPLE_WIDTH(16),
    .SYNC_STAGES (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bit_clk     (bit_clk),
    .frame_clk   (frame_clk),
    .data        (data),
    .sample_left (sample_left),
    .sample_right(sample_right),
    .sample_valid(sample_valid),
    .frame_err   (frame_err),
    .locked      (locked)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (sample_valid) begin
      if (np < 256) begin
        lg_l[np] = sample_left;
        lg_r[np] = sample_right;
        lg_c[np] = cyc;
      end
      np++;
    end
    if (frame_err) ne++;
    if (sample_valid && frame_err) both++;
  end

  task automatic send_bit(input logic w, input logic d);
    frame_clk = w;
    data = d;
    repeat (h) @(negedge clk);
    bit_clk = 1'b1;
    repeat (h) @(negedge clk);
    bit_clk = 1'b0;
  endtask

  // Boundary tick (data ignored), n data bits MSB-first, then padding
  task automatic send_slot(input logic ch, input logic [15:0] w,
                           input int n, input int npad, input logic pv);
    send_bit(ch, 1'b0);
    for (int i = n - 1; i >= 0; i--) send_bit(ch, w[i]);
    for (int i = 0; i < npad; i++) send_bit(ch, pv);
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
    send_slot(1'b0, l, 16, 0, 1'b0);
    send_slot(1'b1, r, 16, 0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (locked !== 1'b0) begin
      n_fail++; $display("FAIL reset_locked got %b want 0", locked);
    end
    n_checks++;
    if (sample_valid !== 1'b0 || frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_pulses got %b%b want 00", sample_valid, frame_err);
    end
    n_checks++;
    if (sample_left !== 16'h0 || sample_right !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_samples got %h/%h want 0000/0000",
               sample_left, sample_right);
    end
  endtask

  task automatic test_lock();
    int p0 = np;
    for (int i = 0; i < 5; i++) send_bit(1'b1, i[0]);
    repeat (4) @(negedge clk);
    n_checks++;
    if (locked !== 1'b0) begin
      n_fail++; $display("FAIL lock_mid_right got %b want 0", locked);
    end
    send_slot(1'b0, 16'h1111, 16, 0, 1'b0);
    n_checks++;
    if (locked !== 1'b1) begin
      n_fail++; $display("FAIL lock_after_edge got %b want 1", locked);
    end
    n_checks++;
    if (np - p0 != 0 || sample_left !== 16'h0) begin
      n_fail++;
      $display("FAIL lock_no_early got pulses %0d left %h want 0 0000",
               np - p0, sample_left);
    end
    send_slot(1'b1, 16'h2222, 16, 0, 1'b0);
    repeat (6) @(negedge clk);
    n_checks++;
    if (np - p0 != 1 || sample_left !== 16'h1111 || sample_right !== 16'h2222)
    begin
      n_fail++;
      $display("FAIL lock_first_pair got %0d %h/%h want 1 1111/2222",
               np - p0, sample_left, sample_right);
    end
  endtask

  task automatic test_basic();
    int p0 = np;
    int e0 = ne;
    send_frame(16'hA5C3, 16'h1234);
    repeat (6) @(negedge clk);
    n_checks++;
    if (np - p0 != 1) begin
      n_fail++; $display("FAIL basic_pulses got %0d want 1", np - p0);
    end
    n_checks++;
    if (sample_left !== 16'hA5C3 || sample_right !== 16'h1234) begin
      n_fail++;
      $display("FAIL basic_pair got %h/%h want a5c3/1234",
               sample_left, sample_right);
    end
    n_checks++;
    if (ne - e0 != 0) begin
      n_fail++; $display("FAIL basic_err got %0d want 0", ne - e0);
    end
  endtask

  task automatic test_long_slots();
    int p0 = np;
    int e0 = ne;
    send_slot(1'b0, 16'h8001, 16, 16, 1'b1);
    send_slot(1'b1, 16'h7FFE, 16, 16, 1'b1);
    send_slot(1'b0, 16'h0001, 16, 16, 1'b1);
    send_slot(1'b1, 16'h4000, 16, 16, 1'b1);
    repeat (6) @(negedge clk);
    n_checks++;
    if (np - p0 != 2 || ne - e0 != 0) begin
      n_fail++;
      $display("FAIL long_counts got %0d pulses %0d errs want 2 0",
               np - p0, ne - e0);
    end
    n_checks++;
    if (lg_l[p0] !== 16'h8001 || lg_r[p0] !== 16'h7FFE) begin
      n_fail++;
      $display("FAIL long_first got %h/%h want 8001/7ffe", lg_l[p0], lg_r[p0]);
    end
    n_checks++;
    if (sample_left !== 16'h0001 || sample_right !== 16'h4000) begin
      n_fail++;
      $display("FAIL long_second got %h/%h want 0001/4000",
               sample_left, sample_right);
    end
  endtask

  task automatic test_short_slot();
    int p0 = np;
    int e0 = ne;
    send_slot(1'b0, 16'h02AA, 10, 0, 1'b0);
    send_slot(1'b1, 16'hBEEF, 16, 0, 1'b0);
    repeat (6) @(negedge clk);
    n_checks++;
    if (ne - e0 != 1) begin
      n_fail++; $display("FAIL short_err got %0d want 1", ne - e0);
    end
    n_checks++;
    if (np - p0 != 0) begin
      n_fail++; $display("FAIL short_no_pulse got %0d want 0", np - p0);
    end
    send_frame(16'h0F0F, 16'hF0F0);
    repeat (6) @(negedge clk);
    n_checks++;
    if (np - p0 != 1 || ne - e0 != 1) begin
      n_fail++;
      $display("FAIL short_recover got %0d pulses %0d errs want 1 1",
               np - p0, ne - e0);
    end
    n_checks++;
    if (sample_left !== 16'h0F0F || sample_right !== 16'hF0F0) begin
      n_fail++;
      $display("FAIL short_pair got %h/%h want 0f0f/f0f0",
               sample_left, sample_right);
    end
  endtask

  task automatic test_reset_mid_word();
    int p0 = np;
    int e0 = ne;
    logic [15:0] w = 16'hABCD;
    send_bit(1'b0, 1'b0);
    for (int i = 15; i >= 8; i--) send_bit(1'b0, w[i]);
    do_reset();
    n_checks++;
    if (sample_left !== 16'h0 || sample_right !== 16'h0 || locked !== 1'b0)
    begin
      n_fail++;
      $display("FAIL rmid_state got %h/%h lock %b want 0000/0000 0",
               sample_left, sample_right, locked);
    end
    for (int i = 7; i >= 0; i--) send_bit(1'b0, w[i]);
    send_slot(1'b1, 16'h5555, 16, 0, 1'b0);
    repeat (6) @(negedge clk);
    n_checks++;
    if (np - p0 != 0 || ne - e0 != 0) begin
      n_fail++;
      $display("FAIL rmid_quiet got %0d pulses %0d errs want 0 0",
               np - p0, ne - e0);
    end
    send_frame(16'hC001, 16'h3003);
    repeat (6) @(negedge clk);
    n_checks++;
    if (np - p0 != 1 || sample_left !== 16'hC001 ||
        sample_right !== 16'h3003 || locked !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_next got %0d %h/%h lock %b want 1 c001/3003 1",
               np - p0, sample_left, sample_right, locked);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] el [100];
    logic [15:0] er [100];
    int p0 = np;
    int per;
    h = 4;
    per = 2 * 17 * 2 * h;
    for (int i = 0; i < 100; i++) begin
      el[i] = 16'($urandom);
      er[i] = 16'($urandom);
    end
    for (int i = 0; i < 100; i++) send_frame(el[i], er[i]);
    repeat (20) @(negedge clk);
    n_checks++;
    if (np - p0 != 100) begin
      n_fail++; $display("FAIL stream_count got %0d want 100", np - p0);
    end else begin
      for (int i = 0; i < 100; i++) begin
        n_checks++;
        if (lg_l[p0+i] !== el[i] || lg_r[p0+i] !== er[i]) begin
          n_fail++;
          $display("FAIL stream_data[%0d] got %h/%h want %h/%h", i,
                   lg_l[p0+i], lg_r[p0+i], el[i], er[i]);
        end
        if (i > 0) begin
          n_checks++;
          if (lg_c[p0+i] - lg_c[p0+i-1] != per) begin
            n_fail++;
            $display("FAIL stream_spacing[%0d] got %0d want %0d", i,
                     lg_c[p0+i] - lg_c[p0+i-1], per);
          end
        end
      end
    end
    n_checks++;
    if (both != 0) begin
      n_fail++; $display("FAIL err_and_valid got %0d want 0", both);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_basic();
    test_long_slots();
    test_short_slot();
    test_reset_mid_word();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
